// File: rtl/vx_issue_pkg.sv
// vx_issue_pkg: shared instruction-buffer and issue-slot types for the warp issue scheduler.
package vx_issue_pkg;
    localparam int IB_RB    = 5;
    localparam int IB_DATAW = 64;
    typedef struct packed {
        logic                wb;
        logic [IB_RB-1:0]    rd;
        logic [IB_RB-1:0]    rs1;
        logic [IB_RB-1:0]    rs2;
        logic [IB_RB-1:0]    rs3;
        logic [IB_DATAW-1:0] data;
    } ibuf_entry_t;
    typedef struct packed {
        logic                wb;
        logic [IB_RB-1:0]    rd;
        logic [IB_DATAW-1:0] data;
    } issue_out_t;
endpackage

// File: rtl/vx_warp_fifo.sv
// vx_warp_fifo: per-warp synchronous instruction FIFO with extra-MSB full/empty pointers.
module vx_warp_fifo
    import vx_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  ibuf_entry_t din,
    output ibuf_entry_t head,
    output logic        empty,
    output logic        full
);
    ibuf_entry_t mem [DEPTH];
    logic [AW:0] wp, rp;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/vx_issue_sched.sv
// vx_issue_sched: per-warp instruction buffers, register scoreboard and round-robin issue.
// Define ISSUE_PERF_EN to add the perf_stalls scoreboard-stall counter port.
module vx_issue_sched
    import vx_issue_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int IBUF_DEPTH = 4,
    parameter int NUM_REGS   = 32,
    parameter int DATAW      = IB_DATAW,
    localparam int WB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RB = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [WB-1:0]    dec_wid,
    input  logic             dec_wb,
    input  logic [RB-1:0]    dec_rd,
    input  logic [RB-1:0]    dec_rs1,
    input  logic [RB-1:0]    dec_rs2,
    input  logic [RB-1:0]    dec_rs3,
    input  logic [DATAW-1:0] dec_data,
    input  logic             wb_valid,
    input  logic [WB-1:0]    wb_wid,
    input  logic [RB-1:0]    wb_rd,
    input  logic             wb_eop,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [WB-1:0]    iss_wid,
    output logic [RB-1:0]    iss_rd,
    output logic             iss_wb,
`ifdef ISSUE_PERF_EN
    output logic [31:0]      perf_stalls,
`endif
    output logic [DATAW-1:0] iss_data
);
    ibuf_entry_t din;
    ibuf_entry_t head [NUM_WARPS];
    issue_out_t  out_q;
    logic [NUM_WARPS-1:0] push, pop, empty, full, elig;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending;
    logic [WB-1:0] rr_ptr, sel, idx;
    logic found, load;

    assign din = '{wb: dec_wb, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, rs3: dec_rs3, data: dec_data};
    assign dec_ready = !full[dec_wid];
    assign load = found && (!iss_valid || iss_ready);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign push[w] = dec_valid && dec_ready && dec_wid == WB'(w);
        assign pop[w]  = load && sel == WB'(w);
        assign elig[w] = !empty[w] && !pending[w][head[w].rs1] && !pending[w][head[w].rs2]
                         && !pending[w][head[w].rs3] && !(head[w].wb && pending[w][head[w].rd]);
        vx_warp_fifo #(.DEPTH(IBUF_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[w]),
            .pop   (pop[w]),
            .din   (din),
            .head  (head[w]),
            .empty (empty[w]),
            .full  (full[w])
        );
    end

    // First eligible warp at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = WB'((int'(rr_ptr) + i) % NUM_WARPS);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid <= 1'b0;
            rr_ptr <= '0;
        end else if (load) begin
            iss_valid <= 1'b1;
            iss_wid <= sel;
            out_q <= '{wb: head[sel].wb, rd: head[sel].rd, data: head[sel].data};
            rr_ptr <= (sel == WB'(NUM_WARPS - 1)) ? '0 : sel + 1'b1;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

    assign iss_wb   = out_q.wb;
    assign iss_rd   = out_q.rd;
    assign iss_data = out_q.data;

    // Set is written last so it overrides a same-cycle writeback clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (wb_valid && wb_eop) pending[wb_wid][wb_rd] <= 1'b0;
            if (load && head[sel].wb && head[sel].rd != '0) pending[sel][head[sel].rd] <= 1'b1;
        end
    end

`ifdef ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) perf_stalls <= '0;
        else if (|(~empty) && !found && (!iss_valid || iss_ready)) perf_stalls <= perf_stalls + 1'b1;
    end
`endif
endmodule

// File: tb/tb_vx_issue_sched.sv
// tb_vx_issue_sched: queue-based reference model with scoreboard monitor for vx_issue_sched.
module tb_vx_issue_sched;
    localparam int NW = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dec_valid, dec_ready, dec_wb, wb_valid, wb_eop, iss_valid, iss_ready, iss_wb;
    logic [1:0] dec_wid, wb_wid, iss_wid;
    logic [4:0] dec_rd, dec_rs1, dec_rs2, dec_rs3, wb_rd, iss_rd;
    logic [63:0] dec_data, iss_data;

    always #5 clk = ~clk;

    vx_issue_sched dut (
        .clk       (clk),
        .reset     (reset),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_wid   (dec_wid),
        .dec_wb    (dec_wb),
        .dec_rd    (dec_rd),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rs3   (dec_rs3),
        .dec_data  (dec_data),
        .wb_valid  (wb_valid),
        .wb_wid    (wb_wid),
        .wb_rd     (wb_rd),
        .wb_eop    (wb_eop),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_wid   (iss_wid),
        .iss_rd    (iss_rd),
        .iss_wb    (iss_wb),
        .iss_data  (iss_data)
    );

    typedef struct {bit wb; int rd; int rs1; int rs2; int rs3; logic [63:0] data;} ment_t;
    typedef struct {int wid; int rd; bit wb; logic [63:0] data;} mexp_t;

    ment_t mq [NW][$];
    bit    pend [NW][32];
    bit    m_valid;
    int    m_rr;
    mexp_t expq [$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ready_head(int w);
        ment_t h;
        if (mq[w].size() == 0) return 1'b0;
        h = mq[w][0];
        return !pend[w][h.rs1] && !pend[w][h.rs2] && !pend[w][h.rs3] && !(h.wb && pend[w][h.rd]);
    endfunction

    // One clock of the reference: uses the inputs that the coming posedge will sample
    task automatic model_step();
        int sel;
        bit full_pre;
        ment_t e;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                mq[w].delete();
                for (int r = 0; r < 32; r++) pend[w][r] = 1'b0;
            end
            m_valid = 1'b0;
            m_rr = 0;
            expq.delete();
            return;
        end
        full_pre = mq[dec_wid].size() == DEPTH;
        sel = -1;
        for (int i = 0; i < NW; i++)
            if (sel < 0 && ready_head((m_rr + i) % NW)) sel = (m_rr + i) % NW;
        if (wb_valid && wb_eop) pend[wb_wid][wb_rd] = 1'b0;
        if ((!m_valid || iss_ready) && sel >= 0) begin
            e = mq[sel].pop_front();
            expq.push_back('{sel, e.rd, e.wb, e.data});
            m_valid = 1'b1;
            m_rr = (sel + 1) % NW;
            if (e.wb && e.rd != 0) pend[sel][e.rd] = 1'b1;
        end else if (iss_ready) begin
            m_valid = 1'b0;
        end
        if (dec_valid && !full_pre)
            mq[dec_wid].push_back('{dec_wb, int'(dec_rd), int'(dec_rs1), int'(dec_rs2), int'(dec_rs3), dec_data});
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        if (!reset) begin
            chk("iss_valid", 64'(iss_valid), 64'(m_valid));
            chk("dec_ready", 64'(dec_ready), 64'(mq[dec_wid].size() < DEPTH));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: the presented slot must match the oldest expected issue
    always @(negedge clk) begin
        if (!reset && iss_valid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL issue: got unexpected wid=%0d data=%0h want none", iss_wid, iss_data);
            end else begin
                chk("iss_wid", 64'(iss_wid), 64'(expq[0].wid));
                chk("iss_rd", 64'(iss_rd), 64'(expq[0].rd));
                chk("iss_wb", 64'(iss_wb), 64'(expq[0].wb));
                chk("iss_data", iss_data, expq[0].data);
                if (iss_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic idle();
        dec_valid = 1'b0; dec_wid = '0; dec_wb = 1'b0; dec_data = '0;
        dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rs3 = '0;
        wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_eop = 1'b0;
        iss_ready = 1'b1;
    endtask

    task automatic push(input int w, input bit wb, input int rd, input int rs1, input logic [63:0] data);
        dec_valid = 1'b1; dec_wid = 2'(w); dec_wb = wb; dec_rd = 5'(rd);
        dec_rs1 = 5'(rs1); dec_rs2 = '0; dec_rs3 = '0; dec_data = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dec_valid = 1'b0;
        wb_valid = 1'b0;
        iss_ready = 1'b0;
        tick();
        reset = 1'b0;
        chk("reset_valid", 64'(iss_valid), 64'd0);
        chk("reset_ready", 64'(dec_ready), 64'd1);
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        idle();
        // Latency: fire at N, issue visible at N+2
        push(0, 1, 5, 0, 64'h1111);
        tick();
        idle();
        chk("lat_n1", 64'(iss_valid), 64'd0);
        tick();
        chk("lat_n2", 64'(iss_valid), 64'd1);
        chk("lat_wid", 64'(iss_wid), 64'd0);
        chk("lat_rd", 64'(iss_rd), 64'd5);
        tick();
        // RAW on r5: stalls until an eop writeback
        push(0, 0, 0, 5, 64'h2222);
        tick();
        idle();
        repeat (4) tick();
        chk("raw_stall", 64'(iss_valid), 64'd0);
        wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 5'd5; wb_eop = 1'b0;
        tick();
        idle();
        repeat (2) tick();
        chk("raw_no_eop", 64'(iss_valid), 64'd0);
        wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 5'd5; wb_eop = 1'b1;
        tick();
        idle();
        chk("raw_wb_t1", 64'(iss_valid), 64'd0);
        tick();
        chk("raw_wb_t2", 64'(iss_valid), 64'd1);
        chk("raw_data", iss_data, 64'h2222);
        tick();
        // Round-robin across four warps
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(i % 4, 0, 0, 0, 64'h100 + 64'(i));
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            chk("rr_valid", 64'(iss_valid), 64'd1);
            chk("rr_wid", 64'(iss_wid), 64'(i % 4));
            tick();
        end
        // Full FIFO and backpressure
        do_reset();
        push(0, 0, 0, 0, 64'hAAAA);
        tick();
        for (int i = 0; i < 4; i++) begin
            push(1, 0, 0, 0, 64'hB0 + 64'(i));
            tick();
        end
        push(1, 0, 0, 0, 64'hBF);
        #1;
        chk("full_w1", 64'(dec_ready), 64'd0);
        dec_wid = 2'd2;
        #1;
        chk("full_w2", 64'(dec_ready), 64'd1);
        dec_wid = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(iss_valid), 64'd1);
            chk("bp_wid", 64'(iss_wid), 64'd0);
            chk("bp_data", iss_data, 64'hAAAA);
            chk("bp_full", 64'(dec_ready), 64'd0);
        end
        dec_valid = 1'b0;
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        chk("full_release", 64'(dec_ready), 64'd1);
        // Same-cycle set and clear of w2 r7: set wins
        do_reset();
        idle();
        push(2, 1, 7, 0, 64'hC1);
        tick();
        push(2, 0, 0, 7, 64'hC2);
        wb_valid = 1'b1; wb_wid = 2'd2; wb_rd = 5'd7; wb_eop = 1'b1;
        tick();
        idle();
        repeat (4) tick();
        chk("collide_stall", 64'(iss_valid), 64'd0);
        // Reset mid-stream flushes everything
        iss_ready = 1'b0;
        push(3, 0, 0, 0, 64'hD1);
        tick();
        push(0, 0, 0, 0, 64'hD2);
        tick();
        push(3, 0, 0, 0, 64'hD3);
        tick();
        do_reset();
        idle();
        repeat (3) tick();
        chk("flush", 64'(iss_valid), 64'd0);
        // Randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            dec_valid = $urandom_range(0, 9) < 6;
            dec_wid = 2'($urandom_range(0, 3));
            dec_wb = 1'($urandom_range(0, 1));
            dec_rd = 5'($urandom_range(0, 7));
            dec_rs1 = 5'($urandom_range(0, 7));
            dec_rs2 = 5'($urandom_range(0, 7));
            dec_rs3 = 5'($urandom_range(0, 7));
            dec_data = {$urandom, $urandom};
            wb_valid = $urandom_range(0, 9) < 4;
            wb_wid = 2'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 7));
            wb_eop = $urandom_range(0, 3) != 0;
            iss_ready = $urandom_range(0, 9) < 7;
            reset = (n == 1500);
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
